// File: rtl/n25q_spi_responder.sv
// n25q_spi_responder
//   SPI-flash responder emulating the N25Q command subset used by our flash
//   master (RDID 0x9F, RDSR 0x05, WREN 0x06, WRDI 0x04, READ 0x03, PP 0x02,
//   SE 0xD8). SPI mode 3, single data line. The bus is oversampled in the
//   ifclk domain (ifclk >= 16x sclk). Byte storage lives outside the block.
// Ports
//   ifclk, reset      : sole clock, synchronous active-high reset
//   sclk, csb, mosi   : SPI pins, asynchronous to ifclk
//   miso, miso_oe     : serial data out (1 when idle) and its tristate enable
//   mem_addr          : byte address of the current memory access
//   mem_rd/mem_rdata  : read strobe; data valid exactly one cycle later
//   mem_wr/mem_wdata  : write strobe and data
//   mem_erase         : erase the 64 KB sector at mem_addr
//   status            : {6'b0, WEL, WIP}
module n25q_spi_responder #(
    parameter logic [23:0] JEDEC_ID     = 24'h20BA18,
    parameter int unsigned PROG_CYCLES  = 1000,
    parameter int unsigned ERASE_CYCLES = 100000
) (
    input  logic        ifclk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        csb,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic [23:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    output logic        mem_erase,
    output logic [7:0]  status
);
    localparam logic [7:0] OP_RDID = 8'h9F, OP_RDSR = 8'h05, OP_WREN = 8'h06,
                           OP_WRDI = 8'h04, OP_READ = 8'h03, OP_PP   = 8'h02,
                           OP_SE   = 8'hD8;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA_OUT, S_DATA_IN, S_IGNORE} state_e;

    // [0],[1] synchronize; [2] holds the previous synchronized sample for edges
    logic [2:0] sclk_sync_q, csb_sync_q;
    logic [1:0] mosi_sync_q;

    state_e      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  out_cnt_q, out_cnt_d;
    logic [5:0]  frame_bits_q, frame_bits_d;
    logic [7:0]  sh_in_q, sh_in_d, sh_out_q, sh_out_d, nxt_q, nxt_d;
    logic [7:0]  opcode_q, opcode_d, mem_wdata_q, mem_wdata_d;
    logic [23:0] addr_q, addr_d, mem_addr_q, mem_addr_d, wip_cnt_q, wip_cnt_d;
    logic [1:0]  id_idx_q, id_idx_d;
    logic        got_byte_q, got_byte_d, rd_to_sh_q, rd_to_sh_d, rd_dly_q, rd_dly_d;
    logic        miso_q, miso_d, miso_oe_q, miso_oe_d;
    logic        mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d, mem_erase_q, mem_erase_d;
    logic        wel_q, wel_d, wip_q, wip_d;

    logic        sclk_rise, sclk_fall, csb_rise, csb_fall, mosi_s;
    logic [7:0]  byte_in, status_w;
    logic [23:0] addr_in;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign csb_rise  = csb_sync_q[1] & ~csb_sync_q[2];
    assign csb_fall  = ~csb_sync_q[1] & csb_sync_q[2];
    assign mosi_s    = mosi_sync_q[1];
    assign byte_in   = {sh_in_q[6:0], mosi_s};
    assign addr_in   = {addr_q[22:0], mosi_s};
    assign status_w  = {6'b0, wel_q, wip_q};

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        out_cnt_d    = out_cnt_q;
        frame_bits_d = frame_bits_q;
        sh_in_d      = sh_in_q;
        sh_out_d     = sh_out_q;
        nxt_d        = nxt_q;
        opcode_d     = opcode_q;
        addr_d       = addr_q;
        id_idx_d     = id_idx_q;
        got_byte_d   = got_byte_q;
        rd_to_sh_d   = rd_to_sh_q;
        rd_dly_d     = mem_rd_q;
        miso_d       = miso_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        mem_erase_d  = 1'b0;
        wel_d        = wel_q;
        wip_d        = wip_q;
        wip_cnt_d    = wip_cnt_q;

        if (wip_q) begin
            if (wip_cnt_q <= 24'd1) begin
                wip_d     = 1'b0;
                wip_cnt_d = 24'd0;
            end else begin
                wip_cnt_d = wip_cnt_q - 24'd1;
            end
        end

        // csb rise wins over any sclk event in the same cycle, so a byte
        // completing together with it is dropped.
        if (csb_rise) begin
            state_d = S_IDLE;
            case (opcode_q)
                OP_WREN: wel_d = 1'b1;
                OP_WRDI: wel_d = 1'b0;
                OP_PP: begin
                    wel_d = 1'b0;
                    if (wel_q && got_byte_q) begin
                        wip_d     = 1'b1;
                        wip_cnt_d = 24'(PROG_CYCLES);
                    end
                end
                OP_SE: begin
                    wel_d = 1'b0;
                    if (wel_q && frame_bits_q == 6'd32) begin
                        mem_erase_d = 1'b1;
                        mem_addr_d  = {addr_q[23:16], 16'h0};
                        wip_d       = 1'b1;
                        wip_cnt_d   = 24'(ERASE_CYCLES);
                    end
                end
                default: ;
            endcase
        end else if (csb_fall) begin
            state_d      = S_CMD;
            bit_cnt_d    = 5'd0;
            out_cnt_d    = 3'd0;
            frame_bits_d = 6'd0;
            opcode_d     = 8'h00;
            got_byte_d   = 1'b0;
            rd_to_sh_d   = 1'b0;
        end else begin
            if (sclk_rise && state_q != S_IDLE && frame_bits_q != 6'd63)
                frame_bits_d = frame_bits_q + 6'd1;

            // Read data return: the first byte goes straight to the shifter
            // and triggers a prefetch of the next address into nxt_q.
            if (rd_dly_q && state_q == S_DATA_OUT) begin
                if (rd_to_sh_q) begin
                    sh_out_d   = mem_rdata;
                    rd_to_sh_d = 1'b0;
                    addr_d     = addr_q + 24'd1;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = addr_q + 24'd1;
                end else begin
                    nxt_d = mem_rdata;
                end
            end

            case (state_q)
                S_CMD: if (sclk_rise) begin
                    sh_in_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        state_d   = S_IGNORE;
                        // while busy only status reads are honored
                        if (!wip_q || byte_in == OP_RDSR) begin
                            opcode_d = byte_in;
                            case (byte_in)
                                OP_RDID: begin
                                    state_d  = S_DATA_OUT;
                                    sh_out_d = JEDEC_ID[23:16];
                                    id_idx_d = 2'd1;
                                end
                                OP_RDSR: begin
                                    state_d  = S_DATA_OUT;
                                    sh_out_d = status_w;
                                end
                                OP_READ, OP_PP, OP_SE: state_d = S_ADDR;
                                default: ;
                            endcase
                        end
                    end
                end
                S_ADDR: if (sclk_rise) begin
                    addr_d    = addr_in;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d = 5'd0;
                        case (opcode_q)
                            OP_READ: begin
                                state_d    = S_DATA_OUT;
                                mem_rd_d   = 1'b1;
                                mem_addr_d = addr_in;
                                rd_to_sh_d = 1'b1;
                            end
                            OP_PP:   state_d = S_DATA_IN;
                            default: state_d = S_IGNORE;
                        endcase
                    end
                end
                S_DATA_IN: if (sclk_rise) begin
                    sh_in_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        if (wel_q) begin
                            mem_wr_d    = 1'b1;
                            mem_wdata_d = byte_in;
                            mem_addr_d  = addr_q;
                            addr_d[7:0] = addr_q[7:0] + 8'd1;  // wrap inside the page
                            got_byte_d  = 1'b1;
                        end
                    end
                end
                S_DATA_OUT: if (sclk_fall) begin
                    miso_d    = sh_out_q[7];
                    out_cnt_d = out_cnt_q + 3'd1;
                    if (out_cnt_q == 3'd7) begin
                        case (opcode_q)
                            OP_RDID: begin
                                case (id_idx_q)
                                    2'd1:    sh_out_d = JEDEC_ID[15:8];
                                    2'd2:    sh_out_d = JEDEC_ID[7:0];
                                    default: sh_out_d = 8'hFF;
                                endcase
                                if (id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
                            end
                            OP_RDSR: sh_out_d = status_w;
                            default: begin
                                sh_out_d   = nxt_q;
                                addr_d     = addr_q + 24'd1;
                                mem_rd_d   = 1'b1;
                                mem_addr_d = addr_q + 24'd1;
                            end
                        endcase
                    end else begin
                        sh_out_d = {sh_out_q[6:0], 1'b1};
                    end
                end
                default: ;
            endcase
        end

        miso_oe_d = (state_d == S_DATA_OUT);
        if (state_d != S_DATA_OUT) miso_d = 1'b1;
    end

    always_ff @(posedge ifclk) begin
        if (reset) begin
            sclk_sync_q  <= 3'b111;
            csb_sync_q   <= 3'b111;
            mosi_sync_q  <= 2'b00;
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            out_cnt_q    <= '0;
            frame_bits_q <= '0;
            sh_in_q      <= '0;
            sh_out_q     <= 8'hFF;
            nxt_q        <= '0;
            opcode_q     <= '0;
            addr_q       <= '0;
            id_idx_q     <= '0;
            got_byte_q   <= 1'b0;
            rd_to_sh_q   <= 1'b0;
            rd_dly_q     <= 1'b0;
            miso_q       <= 1'b1;
            miso_oe_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_erase_q  <= 1'b0;
            wel_q        <= 1'b0;
            wip_q        <= 1'b0;
            wip_cnt_q    <= '0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[1:0], sclk};
            csb_sync_q   <= {csb_sync_q[1:0], csb};
            mosi_sync_q  <= {mosi_sync_q[0], mosi};
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            out_cnt_q    <= out_cnt_d;
            frame_bits_q <= frame_bits_d;
            sh_in_q      <= sh_in_d;
            sh_out_q     <= sh_out_d;
            nxt_q        <= nxt_d;
            opcode_q     <= opcode_d;
            addr_q       <= addr_d;
            id_idx_q     <= id_idx_d;
            got_byte_q   <= got_byte_d;
            rd_to_sh_q   <= rd_to_sh_d;
            rd_dly_q     <= rd_dly_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_erase_q  <= mem_erase_d;
            wel_q        <= wel_d;
            wip_q        <= wip_d;
            wip_cnt_q    <= wip_cnt_d;
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = miso_oe_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_erase = mem_erase_q;
    assign status    = status_w;
endmodule

// File: tb/tb_n25q_spi_responder.sv
// Directed bench for n25q_spi_responder: SPI mode-3 master at ifclk/16,
// memory model returning addr[7:0]^0x5A one cycle after mem_rd.
module tb_n25q_spi_responder;
    localparam int PROG = 1500;
    localparam int ERASE = 1200;

    logic        ifclk = 1'b0, reset = 1'b1, sclk = 1'b1, csb = 1'b1, mosi = 1'b0;
    logic        miso, miso_oe, mem_rd, mem_wr, mem_erase;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00, mem_wdata, status;

    int n_cmp = 0, n_err = 0, multi_cnt = 0;
    logic [23:0] rd_log[$], wr_addr_log[$], erase_log[$];
    logic [7:0]  wr_data_log[$];
    logic [7:0]  tx_buf[0:7], rx_buf[0:7];

    always #5 ifclk = ~ifclk;

    n25q_spi_responder #(.JEDEC_ID(24'h20BA18), .PROG_CYCLES(PROG), .ERASE_CYCLES(ERASE)) dut (
        .ifclk(ifclk), .reset(reset), .sclk(sclk), .csb(csb), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_erase(mem_erase), .status(status));

    always @(posedge ifclk) if (mem_rd) mem_rdata <= mem_addr[7:0] ^ 8'h5A;

    always @(negedge ifclk) begin
        if (!reset) begin
            if (mem_rd) rd_log.push_back(mem_addr);
            if (mem_wr) begin wr_addr_log.push_back(mem_addr); wr_data_log.push_back(mem_wdata); end
            if (mem_erase) erase_log.push_back(mem_addr);
            if ((int'(mem_rd) + int'(mem_wr) + int'(mem_erase)) > 1) multi_cnt++;
        end
    end

    task automatic half_bit();
        repeat (8) @(negedge ifclk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            sclk = 1'b0; mosi = tx[i]; half_bit();
            rx[i] = miso; sclk = 1'b1; half_bit();
        end
    endtask

    task automatic load(input logic [7:0] a, b, c, d, e, f, g);
        tx_buf[0] = a; tx_buf[1] = b; tx_buf[2] = c; tx_buf[3] = d;
        tx_buf[4] = e; tx_buf[5] = f; tx_buf[6] = g; tx_buf[7] = 8'h00;
    endtask

    task automatic frame(input int nbytes, input int extra);
        csb = 1'b0; half_bit();
        for (int b = 0; b < nbytes; b++) spi_bits(tx_buf[b], 8, rx_buf[b]);
        if (extra > 0) spi_bits(tx_buf[nbytes], extra, rx_buf[nbytes]);
        half_bit(); csb = 1'b1;
        repeat (12) @(negedge ifclk);
    endtask

    task automatic read_status(output logic [7:0] st);
        load(8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        frame(2, 0);
        st = rx_buf[1];
    endtask

    task automatic test_reset();
        reset = 1'b1; repeat (5) @(negedge ifclk);
        reset = 1'b0; repeat (5) @(negedge ifclk);
        n_cmp++; if (miso !== 1'b1) begin n_err++; $display("FAIL reset_miso: got %b want 1", miso); end
        n_cmp++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe: got %b want 0", miso_oe); end
        n_cmp++; if (status !== 8'h00) begin n_err++; $display("FAIL reset_status: got %h want 00", status); end
        n_cmp++; if (mem_addr !== 24'h0) begin n_err++; $display("FAIL reset_addr: got %h want 000000", mem_addr); end
        n_cmp++; if ({mem_rd, mem_wr, mem_erase} !== 3'b000) begin n_err++; $display("FAIL reset_strobes: got %b want 000", {mem_rd, mem_wr, mem_erase}); end
        n_cmp++; if (mem_wdata !== 8'h00) begin n_err++; $display("FAIL reset_wdata: got %h want 00", mem_wdata); end
    endtask

    task automatic test_read_id();
        logic [7:0] exp[4];
        logic [7:0] rx;
        exp = '{8'h20, 8'hBA, 8'h18, 8'hFF};
        csb = 1'b0; half_bit();
        n_cmp++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL rdid_oe_pre: got %b want 0", miso_oe); end
        spi_bits(8'h9F, 8, rx);
        for (int i = 0; i < 4; i++) begin
            spi_bits(8'h00, 8, rx);
            n_cmp++; if (rx !== exp[i]) begin n_err++; $display("FAIL rdid_byte%0d: got %h want %h", i, rx, exp[i]); end
        end
        n_cmp++; if (miso_oe !== 1'b1) begin n_err++; $display("FAIL rdid_oe_active: got %b want 1", miso_oe); end
        half_bit(); csb = 1'b1; repeat (4) @(negedge ifclk);
        n_cmp++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL rdid_oe_post: got %b want 0", miso_oe); end
        n_cmp++; if (miso !== 1'b1) begin n_err++; $display("FAIL rdid_miso_post: got %b want 1", miso); end
        repeat (8) @(negedge ifclk);
    endtask

    task automatic test_protected_program();
        int w0;
        logic [7:0] st;
        w0 = wr_addr_log.size();
        load(8'h02, 8'h00, 8'h00, 8'h10, 8'hAA, 8'h00, 8'h00);
        frame(5, 0);
        n_cmp++; if (wr_addr_log.size() != w0) begin n_err++; $display("FAIL prot_no_write: got %0d writes want 0", wr_addr_log.size() - w0); end
        read_status(st);
        n_cmp++; if (st !== 8'h00) begin n_err++; $display("FAIL prot_status: got %h want 00", st); end
    endtask

    task automatic test_program_wrap();
        int w0, r0;
        logic [7:0] st;
        logic [23:0] ea[3];
        logic [7:0] ed[3];
        ea = '{24'h0012FE, 24'h0012FF, 24'h001200};
        ed = '{8'h11, 8'h22, 8'h33};
        w0 = wr_addr_log.size();
        load(8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00); frame(1, 0);
        load(8'h02, 8'h00, 8'h12, 8'hFE, 8'h11, 8'h22, 8'h33); frame(7, 0);
        n_cmp++; if (wr_addr_log.size() != w0 + 3) begin n_err++; $display("FAIL pp_write_count: got %0d want 3", wr_addr_log.size() - w0); end
        if (wr_addr_log.size() >= w0 + 3) begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (wr_addr_log[w0+i] !== ea[i]) begin n_err++; $display("FAIL pp_addr%0d: got %h want %h", i, wr_addr_log[w0+i], ea[i]); end
                n_cmp++; if (wr_data_log[w0+i] !== ed[i]) begin n_err++; $display("FAIL pp_data%0d: got %h want %h", i, wr_data_log[w0+i], ed[i]); end
            end
        end
        read_status(st);
        n_cmp++; if (st !== 8'h01) begin n_err++; $display("FAIL pp_status_busy: got %h want 01", st); end
        r0 = rd_log.size();
        load(8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00); frame(5, 0);
        n_cmp++; if (rd_log.size() != r0) begin n_err++; $display("FAIL pp_busy_read: got %0d reads want 0", rd_log.size() - r0); end
        repeat (PROG) @(negedge ifclk);
        read_status(st);
        n_cmp++; if (st !== 8'h00) begin n_err++; $display("FAIL pp_status_done: got %h want 00", st); end
    endtask

    task automatic test_read_wrap();
        int r0;
        logic [23:0] ea[3];
        logic [7:0] ed[3];
        ea = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000};
        ed = '{8'hA4, 8'hA5, 8'h5A};
        r0 = rd_log.size();
        load(8'h03, 8'hFF, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00); frame(7, 0);
        n_cmp++; if (rd_log.size() < r0 + 3) begin n_err++; $display("FAIL rd_count: got %0d want >=3", rd_log.size() - r0); end
        if (rd_log.size() >= r0 + 3) begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (rd_log[r0+i] !== ea[i]) begin n_err++; $display("FAIL rd_addr%0d: got %h want %h", i, rd_log[r0+i], ea[i]); end
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (rx_buf[4+i] !== ed[i]) begin n_err++; $display("FAIL rd_data%0d: got %h want %h", i, rx_buf[4+i], ed[i]); end
        end
    endtask

    task automatic test_erase();
        int e0;
        logic [7:0] st;
        e0 = erase_log.size();
        load(8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00); frame(1, 0);
        load(8'hD8, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00); frame(4, 0);
        n_cmp++; if (erase_log.size() != e0 + 1) begin n_err++; $display("FAIL se_count: got %0d want 1", erase_log.size() - e0); end
        if (erase_log.size() >= e0 + 1) begin
            n_cmp++; if (erase_log[e0] !== 24'h340000) begin n_err++; $display("FAIL se_addr: got %h want 340000", erase_log[e0]); end
        end
        read_status(st);
        n_cmp++; if (st !== 8'h01) begin n_err++; $display("FAIL se_status_busy: got %h want 01", st); end
        repeat (ERASE) @(negedge ifclk);
        read_status(st);
        n_cmp++; if (st !== 8'h00) begin n_err++; $display("FAIL se_status_done: got %h want 00", st); end
        load(8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00); frame(1, 0);
        load(8'hD8, 8'h34, 8'h56, 8'h78, 8'hFF, 8'h00, 8'h00); frame(4, 1);
        n_cmp++; if (erase_log.size() != e0 + 1) begin n_err++; $display("FAIL se33_no_erase: got %0d want 1", erase_log.size() - e0); end
        read_status(st);
        n_cmp++; if (st !== 8'h00) begin n_err++; $display("FAIL se33_wel_clear: got %h want 00", st); end
    endtask

    task automatic test_abort();
        int w0;
        logic [7:0] st;
        w0 = wr_addr_log.size();
        load(8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00); frame(1, 0);
        load(8'h02, 8'h00, 8'h01, 8'h00, 8'hC3, 8'h00, 8'h00); frame(4, 5);
        n_cmp++; if (wr_addr_log.size() != w0) begin n_err++; $display("FAIL abort_no_write: got %0d writes want 0", wr_addr_log.size() - w0); end
        read_status(st);
        n_cmp++; if (st !== 8'h00) begin n_err++; $display("FAIL abort_status: got %h want 00", st); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx;
        csb = 1'b0; half_bit();
        spi_bits(8'h03, 8, rx); spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx); spi_bits(8'h20, 8, rx);
        spi_bits(8'h00, 3, rx);
        reset = 1'b1; repeat (2) @(negedge ifclk);
        n_cmp++; if (miso !== 1'b1) begin n_err++; $display("FAIL rst_mid_miso: got %b want 1", miso); end
        n_cmp++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL rst_mid_oe: got %b want 0", miso_oe); end
        n_cmp++; if (mem_addr !== 24'h0) begin n_err++; $display("FAIL rst_mid_addr: got %h want 000000", mem_addr); end
        n_cmp++; if (status !== 8'h00) begin n_err++; $display("FAIL rst_mid_status: got %h want 00", status); end
        sclk = 1'b1; csb = 1'b1; repeat (5) @(negedge ifclk);
        reset = 1'b0; repeat (5) @(negedge ifclk);
        load(8'h9F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00); frame(5, 0);
        n_cmp++; if ({rx_buf[1], rx_buf[2], rx_buf[3], rx_buf[4]} !== 32'h20BA18FF) begin
            n_err++; $display("FAIL rst_then_rdid: got %h%h%h%h want 20ba18ff", rx_buf[1], rx_buf[2], rx_buf[3], rx_buf[4]);
        end
    endtask

    task automatic test_exclusive();
        n_cmp++; if (multi_cnt != 0) begin n_err++; $display("FAIL strobe_exclusive: got %0d overlaps want 0", multi_cnt); end
    endtask

    initial begin
        test_reset();
        test_read_id();
        test_protected_program();
        test_program_wrap();
        test_read_wrap();
        test_erase();
        test_abort();
        test_reset_mid_read();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
